// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem bus-master slice.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the initiator, its watchdog and anything that decodes iomem pages.
package iomem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } iomem_state_t;

    localparam logic [7:0] IOMEM_GPIO_PAGE = 8'h03;
    localparam logic [3:0] WSTRB_NONE      = 4'h0;
    localparam logic [3:0] WSTRB_ALL       = 4'hF;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } iomem_cmd_t;

    // Reads must never present byte enables on the bus.
    function automatic logic [3:0] bus_wstrb(input logic we, input logic [3:0] wstrb);
        return we ? wstrb : WSTRB_NONE;
    endfunction

endpackage

// File: rtl/iomem_watchdog.sv
// Wait-cycle counter that flags when a bus transaction has waited long enough.
// expired is a decode of the count register, valid in the same cycle.
// No flow control; clr has priority over en, count holds once expired.
module iomem_watchdog
    import iomem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // expired marks the last wait cycle, so the bus sees exactly TIMEOUT_CYCLES valid cycles.
    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            count_q <= '0;
        end else if (en && !expired) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus master fed by a valid/ready command port.
// Command accepted at T drives the bus from T+1; response one cycle after iomem_ready or timeout.
// cmd_ready low while busy or in reset; response held until rsp_ready, no command buffering.
module iomem_initiator
    import iomem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_wstrb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             iomem_valid,
    input  logic             iomem_ready,
    output logic [3:0]       iomem_wstrb,
    output logic [31:0]      iomem_addr,
    output logic [31:0]      iomem_wdata,
    input  logic [31:0]      iomem_rdata,
    output logic [CNT_W-1:0] txn_count,
    output logic [7:0]       err_count
);

    iomem_state_t state_q, state_d;
    iomem_cmd_t   cmd_q;
    logic         accept;
    logic         done_ok;
    logic         done_err;
    logic         wd_en;
    logic         wd_expired;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        wd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = resetn;
                if (cmd_valid && resetn) begin
                    accept  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // A completion in the final wait cycle beats the timeout.
                if (iomem_ready) begin
                    done_ok = 1'b1;
                    state_d = RESP;
                end else begin
                    wd_en = 1'b1;
                    if (wd_expired) begin
                        done_err = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    iomem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .clr    (accept),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cmd_q       <= '0;
            iomem_valid <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            txn_count   <= '0;
            err_count   <= '0;
        end else begin
            if (accept) begin
                cmd_q.we    <= cmd_we;
                cmd_q.addr  <= cmd_addr;
                cmd_q.wdata <= cmd_wdata;
                cmd_q.wstrb <= bus_wstrb(cmd_we, cmd_wstrb);
                iomem_valid <= 1'b1;
            end
            if (done_ok || done_err) begin
                iomem_valid <= 1'b0;
                rsp_err     <= done_err;
                rsp_rdata   <= (done_ok && !cmd_q.we) ? iomem_rdata : '0;
                txn_count   <= txn_count + CNT_W'(1);
                if (done_err && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    assign iomem_addr  = cmd_q.addr;
    assign iomem_wdata = cmd_q.wdata;
    assign iomem_wstrb = cmd_q.wstrb;

endmodule

// File: tb/tb_iomem_initiator.sv
// Bench for iomem_initiator: GPIO-style responder plus a word-memory reference model.
module tb_iomem_initiator;
    import iomem_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        iomem_valid, iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    iomem_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .txn_count(txn_count), .err_count(err_count)
    );

    int n_pass = 0;
    int n_total = 0;
    int exp_txn = 0;
    int exp_err = 0;

    logic [31:0] ref_mem [bit [31:0]];
    logic [31:0] dev_mem [bit [31:0]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Responder: answers page 0x03 after resp_delay cycles of valid; garbage rdata otherwise.
    int          resp_delay = 1;
    logic        resp_rdy_r = 1'b0;
    logic        spur_ready = 1'b0;
    logic [31:0] resp_rdata_r = 32'h0;
    assign iomem_ready = resp_rdy_r | spur_ready;
    assign iomem_rdata = resp_rdata_r;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (iomem_valid && iomem_addr[31:24] == IOMEM_GPIO_PAGE && cnt == resp_delay) begin
                if (iomem_wstrb != WSTRB_NONE)
                    dev_mem[iomem_addr] = merge(dev_mem.exists(iomem_addr) ? dev_mem[iomem_addr] : 32'h0,
                                                iomem_wdata, iomem_wstrb);
                resp_rdata_r = dev_mem.exists(iomem_addr) ? dev_mem[iomem_addr] : 32'h0;
                resp_rdy_r   = 1'b1;
                cnt++;
            end else begin
                resp_rdy_r   = 1'b0;
                resp_rdata_r = $urandom;
                cnt          = iomem_valid ? cnt + 1 : 0;
            end
        end
    end

    logic [31:0] rd;
    logic        er;
    int          vc;
    logic [3:0]  bs;

    // Issue one command; returns at the first negedge showing rsp_valid, handshake not yet done.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                           output int vcyc, output logic [3:0] bstrb);
        bit acc;
        bit got;
        acc = 0; got = 0; vcyc = 0; bstrb = 'x; rdata = 'x; err = 'x;
        cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb; cmd_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = (cmd_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL cmd_accept: cmd_ready never seen in 50 cycles, required 1");
            return;
        end
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (iomem_valid === 1'b1) begin
                vcyc++;
                bstrb = iomem_wstrb;
            end
            got = (rsp_valid === 1'b1);
        end
        if (!got) begin
            n_total++;
            $display("FAIL rsp_wait: rsp_valid never seen in 200 cycles, required 1");
            return;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0300_0000;
        cmd_wdata = 32'h1; cmd_wstrb = WSTRB_ALL; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); else n_pass++;
        n_total++; if (iomem_valid !== 1'b0) $display("FAIL rst_iomem_valid: got %b want 0", iomem_valid); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if ({iomem_addr, iomem_wdata, iomem_wstrb} !== 68'h0)
            $display("FAIL rst_bus: got %h/%h/%h want 0", iomem_addr, iomem_wdata, iomem_wstrb); else n_pass++;
        n_total++; if ({rsp_rdata, rsp_err} !== 33'h0) $display("FAIL rst_rsp: got %h/%b want 0", rsp_rdata, rsp_err); else n_pass++;
        n_total++; if ({txn_count, err_count} !== 24'h0) $display("FAIL rst_counts: got %0d/%0d want 0", txn_count, err_count); else n_pass++;
        @(posedge clk);
        #1;
        resetn = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_gpio_write_read();
        resp_delay = 1;
        run_txn(1'b1, 32'h0300_0000, 32'hA5A5_0005, WSTRB_ALL, rd, er, vc, bs);
        ref_mem[32'h0300_0000] = merge(ref_read(32'h0300_0000), 32'hA5A5_0005, WSTRB_ALL);
        exp_txn++;
        n_total++; if (vc !== 2) $display("FAIL gpio_wr_valid_cycles: got %0d want 2", vc); else n_pass++;
        n_total++; if (bs !== WSTRB_ALL) $display("FAIL gpio_wr_wstrb: got %h want f", bs); else n_pass++;
        n_total++; if (er !== 1'b0 || rd !== 32'h0) $display("FAIL gpio_wr_rsp: got %h/%b want 0/0", rd, er); else n_pass++;
        finish_rsp();
        run_txn(1'b0, 32'h0300_0000, $urandom, 4'($urandom), rd, er, vc, bs);
        exp_txn++;
        n_total++; if (vc !== 2) $display("FAIL gpio_rd_valid_cycles: got %0d want 2", vc); else n_pass++;
        n_total++; if (bs !== WSTRB_NONE) $display("FAIL gpio_rd_wstrb: got %h want 0", bs); else n_pass++;
        n_total++; if (rd !== ref_read(32'h0300_0000)) $display("FAIL gpio_rd_data: got %h want %h", rd, ref_read(32'h0300_0000)); else n_pass++;
        n_total++; if (txn_count !== 16'(exp_txn)) $display("FAIL gpio_txn_count: got %0d want %0d", txn_count, exp_txn); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_byte_strobe();
        resp_delay = 1;
        run_txn(1'b1, 32'h0300_0008, 32'h0000_00FF, 4'h1, rd, er, vc, bs);
        ref_mem[32'h0300_0008] = merge(ref_read(32'h0300_0008), 32'h0000_00FF, 4'h1);
        exp_txn++;
        n_total++; if (bs !== 4'h1) $display("FAIL strb_wr_wstrb: got %h want 1", bs); else n_pass++;
        finish_rsp();
        run_txn(1'b0, 32'h0300_0008, 32'hDEAD_BEEF, WSTRB_ALL, rd, er, vc, bs);
        exp_txn++;
        n_total++; if (bs !== WSTRB_NONE) $display("FAIL strb_rd_wstrb: got %h want 0", bs); else n_pass++;
        n_total++; if (rd !== 32'h0000_00FF) $display("FAIL strb_rd_data: got %h want 000000ff", rd); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_timeout();
        logic [15:0] t0;
        run_txn(1'b0, 32'h0400_0000, 32'h0, WSTRB_NONE, rd, er, vc, bs);
        exp_txn++; exp_err++;
        t0 = txn_count;
        n_total++; if (vc !== TO) $display("FAIL to_valid_cycles: got %0d want %0d", vc, TO); else n_pass++;
        n_total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL to_rsp: got %h/%b want 0/1", rd, er); else n_pass++;
        n_total++; if (err_count !== 8'(exp_err)) $display("FAIL to_err_count: got %0d want %0d", err_count, exp_err); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        spur_ready = 1'b1;
        @(posedge clk);
        #1;
        spur_ready = 1'b0;
        @(negedge clk);
        n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
            $display("FAIL late_ready_resp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
        n_total++; if (txn_count !== 16'(exp_txn) || iomem_valid !== 1'b0)
            $display("FAIL late_ready_state: got txn=%0d valid=%b want %0d/0 (was %0d)", txn_count, iomem_valid, exp_txn, t0); else n_pass++;
        finish_rsp();
        spur_ready = 1'b1;
        @(posedge clk);
        #1;
        spur_ready = 1'b0;
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || txn_count !== 16'(exp_txn))
            $display("FAIL idle_spurious: got rdy=%b v=%b txn=%0d want 1/0/%0d", cmd_ready, rsp_valid, txn_count, exp_txn); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rsp_hold();
        logic [31:0] erd;
        bit got;
        resp_delay = $urandom_range(0, 3);
        erd = ref_read(32'h0300_0000);
        run_txn(1'b0, 32'h0300_0000, 32'h0, WSTRB_NONE, rd, er, vc, bs);
        exp_txn++;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0300_0008; cmd_wstrb = WSTRB_NONE;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== erd)
                $display("FAIL hold_rsp[%0d]: got v=%b d=%h want 1/%h", i, rsp_valid, rsp_rdata, erd); else n_pass++;
            n_total++; if (cmd_ready !== 1'b0) $display("FAIL hold_cmd_ready[%0d]: got %b want 0", i, cmd_ready); else n_pass++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1 || iomem_valid !== 1'b0)
            $display("FAIL post_hs: got rdy=%b valid=%b want 1/0", cmd_ready, iomem_valid); else n_pass++;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_total++; if (iomem_valid !== 1'b1) $display("FAIL held_cmd_accept: got %b want 1", iomem_valid); else n_pass++;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            got = (rsp_valid === 1'b1);
            if (!got) @(negedge clk);
        end
        exp_txn++;
        n_total++; if (!got || rsp_rdata !== ref_read(32'h0300_0008))
            $display("FAIL held_cmd_rsp: got v=%b d=%h want 1/%h", rsp_valid, rsp_rdata, ref_read(32'h0300_0008)); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        logic [31:0] wd;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0400_0000; cmd_wstrb = WSTRB_NONE;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_txn = 0; exp_err = 0;
        @(negedge clk);
        n_total++; if (iomem_valid !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL midrst_valid: got iomem=%b rsp=%b want 0/0", iomem_valid, rsp_valid); else n_pass++;
        n_total++; if (txn_count !== 16'h0 || err_count !== 8'h0)
            $display("FAIL midrst_counts: got %0d/%0d want 0/0", txn_count, err_count); else n_pass++;
        @(posedge clk);
        #1;
        resp_delay = 2;
        wd = $urandom;
        run_txn(1'b1, 32'h0300_0010, wd, WSTRB_ALL, rd, er, vc, bs);
        ref_mem[32'h0300_0010] = wd;
        exp_txn++;
        finish_rsp();
        run_txn(1'b0, 32'h0300_0010, 32'h0, WSTRB_NONE, rd, er, vc, bs);
        exp_txn++;
        n_total++; if (rd !== wd || er !== 1'b0 || vc !== 3)
            $display("FAIL midrst_next: got d=%h e=%b vc=%0d want %h/0/3", rd, er, vc, wd); else n_pass++;
        n_total++; if (txn_count !== 16'(exp_txn)) $display("FAIL midrst_txn: got %0d want %0d", txn_count, exp_txn); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_random();
        logic        we_r;
        logic [31:0] a, wd, erd;
        logic [3:0]  st;
        bit          g;
        int          evc;
        for (int i = 0; i < 40; i++) begin
            resp_delay = $urandom_range(0, 3);
            g    = ($urandom_range(0, 4) != 0);
            we_r = 1'($urandom);
            a    = g ? {IOMEM_GPIO_PAGE, 24'(4 * $urandom_range(0, 7))} : {8'h04, 24'($urandom)};
            wd   = $urandom;
            st   = 4'($urandom);
            erd  = (g && !we_r) ? ref_read(a) : 32'h0;
            evc  = g ? resp_delay + 1 : TO;
            if (g && we_r) ref_mem[a] = merge(ref_read(a), wd, st);
            exp_txn++;
            if (!g && exp_err < 255) exp_err++;
            run_txn(we_r, a, wd, st, rd, er, vc, bs);
            n_total++; if (rd !== erd || er !== !g)
                $display("FAIL rnd_rsp[%0d]: got d=%h e=%b want %h/%b", i, rd, er, erd, !g); else n_pass++;
            n_total++; if (vc !== evc || bs !== (we_r ? st : WSTRB_NONE))
                $display("FAIL rnd_bus[%0d]: got vc=%0d strb=%h want %0d/%h", i, vc, bs, evc, we_r ? st : WSTRB_NONE); else n_pass++;
            n_total++; if (txn_count !== 16'(exp_txn) || err_count !== 8'(exp_err))
                $display("FAIL rnd_counts[%0d]: got %0d/%0d want %0d/%0d", i, txn_count, err_count, exp_txn, exp_err); else n_pass++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            finish_rsp();
        end
    endtask

    task automatic test_saturation();
        int bad;
        bad = 0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_txn = 0; exp_err = 0;
        for (int i = 0; i < 300; i++) begin
            run_txn(1'b0, 32'h0400_0100, 32'h0, WSTRB_NONE, rd, er, vc, bs);
            exp_txn++;
            if (exp_err < 255) exp_err++;
            if (er !== 1'b1) bad++;
            if (i == 254 || i == 255) begin
                n_total++; if (err_count !== 8'(exp_err))
                    $display("FAIL sat_edge[%0d]: got %0d want %0d", i, err_count, exp_err); else n_pass++;
            end
            finish_rsp();
        end
        n_total++; if (bad !== 0) $display("FAIL sat_rsp_err: got %0d non-error responses want 0", bad); else n_pass++;
        n_total++; if (err_count !== 8'd255) $display("FAIL sat_err_count: got %0d want 255", err_count); else n_pass++;
        n_total++; if (txn_count !== 16'd300) $display("FAIL sat_txn_count: got %0d want 300", txn_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_gpio_write_read();
        test_byte_strobe();
        test_timeout();
        test_rsp_hold();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/iomem_initiator.md
# iomem_initiator

Bus-master end of the iomem peripheral interface: takes single-word read/write commands on a valid/ready command port, runs them as iomem transactions (valid held until ready), and returns read data or a timeout error on a valid/ready response port. It drives the same iomem bus the SoC core uses, so a test harness or serial debug bridge can reach GPIO and other iomem peripherals (e.g. the 0x03xx_xxxx GPIO window) without the CPU.

## Interface
- TIMEOUT_CYCLES, 255: wait cycles (iomem_valid high, iomem_ready low) before the transaction is abandoned; legal range 1..65535.
- CNT_W, 16: width of the transaction counter.

- clk  in  1  clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address, driven unmodified.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  byte enables for writes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes and on error.
- rsp_err  out  1  1 = timeout.
- iomem_valid  out  1  transaction request.
- iomem_ready  in  1  responder completion strobe.
- iomem_wstrb  out  4  0 for reads, cmd_wstrb for writes.
- iomem_addr  out  32  transaction address.
- iomem_wdata  out  32  transaction write data.
- iomem_rdata  in  32  read data, valid in the iomem_ready cycle.
- txn_count  out  CNT_W  completed transactions (ok + error), wraps.
- err_count  out  8  timeouts, saturates at 255.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: cmd_ready = 1. On cmd_valid: latch addr, wdata, wstrb (forced 0 when cmd_we = 0), we; clear wait counter; go BUS.
- BUS: iomem_valid = 1, addr/wdata/wstrb stable for the whole state.
  - iomem_ready = 1: capture iomem_rdata (reads) or 0 (writes), rsp_err = 0, go RESP.
  - iomem_ready = 0: increment wait counter; when it equals TIMEOUT_CYCLES, rsp_rdata = 0, rsp_err = 1, go RESP.
  - iomem_ready = 1 in the cycle the counter reaches TIMEOUT_CYCLES: success wins.
- RESP: rsp_valid = 1, rsp_rdata/rsp_err stable until handshake; on rsp_ready go IDLE.
- iomem_ready in IDLE or RESP (late or spurious strobe) is ignored; no state or data change.
- txn_count increments, and err_count on error, in the BUS→RESP transition cycle.
- Only one outstanding transaction; no command buffering.

## Timing
- Reset (resetn low at a clock edge): state IDLE, iomem_valid 0, iomem_addr/wdata/wstrb 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, txn_count 0, err_count 0. cmd_ready is 0 while resetn is low.
- Reset mid-transaction: iomem_valid drops at the next edge, pending response discarded, no counter update.
- Command accepted at edge T → iomem_valid high from T+1.
- iomem_ready sampled high at edge T+k → iomem_valid low and rsp_valid high from T+k+1. The initiator never holds valid into the cycle after ready, which suits one-cycle ready pulses.
- Timeout: iomem_valid high for exactly TIMEOUT_CYCLES cycles, then rsp_valid with rsp_err.
- Response accepted at edge R → cmd_ready high from R+1. Against a ready-next-cycle responder, minimum is 4 cycles per transaction.
- All outputs are registered except cmd_ready and rsp_valid, which are state decodes.

## Structure
- Shared package iomem_pkg holds:
  - state enum (IDLE, BUS, RESP);
  - IOMEM_GPIO_PAGE = 8'h03;
  - WSTRB_NONE = 4'h0, WSTRB_ALL = 4'hF.
- One natural sub-module, iomem_watchdog: wait counter with clear/enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.

## Test plan
- GPIO-style responder (ready one cycle after valid, page 0x03). Write 0x03000000, wdata 0xA5A5_0005, wstrb 0xF, then read back → iomem_valid high exactly 2 cycles each; rsp_rdata 0xA5A5_0005; txn_count 2.
- Write wstrb 0x1, wdata 0x0000_00FF over gpio 0 → read returns 0x0000_00FF; read transaction shows iomem_wstrb 0.
- Responder never answers (address 0x04000000), TIMEOUT_CYCLES 8 → iomem_valid high 8 cycles; rsp_err 1, rsp_rdata 0; err_count 1. A late ready 3 cycles later has no effect.
- rsp_ready held low 5 cycles → rsp_valid/rsp_rdata stable; cmd_ready 0 throughout; cmd_valid held high is not accepted until the cycle after the response handshake.
- resetn pulsed low during BUS → iomem_valid 0 next cycle; counters 0; the next command completes normally.
- 300 forced timeouts → err_count saturates at 255; txn_count equals 300.
